// File: rtl/ahb_response_mux.sv
// ahb_response_mux
//   Data-phase return path of the AHB-Lite interconnect. The decoder's
//   subordinate selects are captured at each address-phase completion.
//   That captured select then steers the chosen subordinate's
//   HRDATA/HREADYOUT/HRESP back to the manager. The block also contains
//   the default subordinate, which answers unmapped active transfers with
//   a two-cycle ERROR. HREADY is the bus-wide ready that goes back to the
//   decoder and to all subordinates.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL1..3, HSELd       address-phase selects (priority 1 > 2 > 3 > d)
//   HTRANS                manager transfer type (bit 1 set = NONSEQ/SEQ)
//   HRDATAx/HREADYOUTx/HRESPx   subordinate responses
//   HRDATA/HREADY/HRESP   muxed response to the manager
module ahb_response_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL1,
    input  logic                  HSEL2,
    input  logic                  HSEL3,
    input  logic                  HSELd,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HRDATA1,
    input  logic [DATA_WIDTH-1:0] HRDATA2,
    input  logic [DATA_WIDTH-1:0] HRDATA3,
    input  logic                  HREADYOUT1,
    input  logic                  HREADYOUT2,
    input  logic                  HREADYOUT3,
    input  logic [RESP_WIDTH-1:0] HRESP1,
    input  logic [RESP_WIDTH-1:0] HRESP2,
    input  logic [RESP_WIDTH-1:0] HRESP3,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic [RESP_WIDTH-1:0] HRESP
);

    typedef enum logic [2:0] {SEL_NONE, SEL_S1, SEL_S2, SEL_S3, SEL_DEF} sel_t;
    typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

    sel_t    sel_q;
    sel_t    sel_next;
    dstate_t dstate;
    logic    hreadyd;
    logic    hrespd;

    // NONSEQ and SEQ are the only transfer types that need a real response.
    logic htrans_active;
    assign htrans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);

    // Priority resolution of the address-phase selects.
    always_comb begin
        sel_next = SEL_NONE;
        if (HSEL1)      sel_next = SEL_S1;
        else if (HSEL2) sel_next = SEL_S2;
        else if (HSEL3) sel_next = SEL_S3;
        else if (HSELd) sel_next = SEL_DEF;
    end

    // An active transfer to the default subordinate, accepted this cycle.
    logic def_err_start;
    assign def_err_start = HREADY && (sel_next == SEL_DEF) && htrans_active;

    // Data-phase select: loads only when the current data phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            sel_q <= SEL_NONE;
        else if (HREADY)
            sel_q <= sel_next;
    end

    // Default-subordinate responder. Its outputs are registered alongside
    // the state, so HREADYd/HRESPd always match the state being entered.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dstate  <= D_IDLE;
            hreadyd <= 1'b1;
            hrespd  <= 1'b0;
        end else begin
            case (dstate)
                D_IDLE: begin
                    if (def_err_start) begin
                        dstate  <= D_ERR1;
                        hreadyd <= 1'b0;
                        hrespd  <= 1'b1;
                    end
                end
                D_ERR1: begin
                    dstate  <= D_ERR2;
                    hreadyd <= 1'b1;
                    hrespd  <= 1'b1;
                end
                D_ERR2: begin
                    // A new error transfer can be accepted in ERR2, which
                    // gives back-to-back ERROR responses.
                    if (def_err_start) begin
                        dstate  <= D_ERR1;
                        hreadyd <= 1'b0;
                        hrespd  <= 1'b1;
                    end else begin
                        dstate  <= D_IDLE;
                        hreadyd <= 1'b1;
                        hrespd  <= 1'b0;
                    end
                end
                default: begin
                    dstate  <= D_IDLE;
                    hreadyd <= 1'b1;
                    hrespd  <= 1'b0;
                end
            endcase
        end
    end

    // Response mux. When no subordinate is selected (unmapped region 0),
    // the transfer completes as a zero-wait OKAY.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = '0;
        case (sel_q)
            SEL_S1: begin
                HRDATA = HRDATA1;
                HREADY = HREADYOUT1;
                HRESP  = HRESP1;
            end
            SEL_S2: begin
                HRDATA = HRDATA2;
                HREADY = HREADYOUT2;
                HRESP  = HRESP2;
            end
            SEL_S3: begin
                HRDATA = HRDATA3;
                HREADY = HREADYOUT3;
                HRESP  = HRESP3;
            end
            SEL_DEF: begin
                HREADY = hreadyd;
                HRESP  = RESP_WIDTH'(hrespd);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_response_mux.sv
module tb_ahb_response_mux;

    localparam int DW = 32;
    localparam int RW = 1;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL1, HSEL2, HSEL3, HSELd;
    logic [1:0]    HTRANS;
    logic [DW-1:0] HRDATA1, HRDATA2, HRDATA3;
    logic          HREADYOUT1, HREADYOUT2, HREADYOUT3;
    logic [RW-1:0] HRESP1, HRESP2, HRESP3;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic [RW-1:0] HRESP;

    int tests = 0;
    int fails = 0;

    ahb_response_mux #(.DATA_WIDTH(DW), .RESP_WIDTH(RW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HSEL1(HSEL1), .HSEL2(HSEL2), .HSEL3(HSEL3), .HSELd(HSELd),
        .HTRANS(HTRANS),
        .HRDATA1(HRDATA1), .HRDATA2(HRDATA2), .HRDATA3(HRDATA3),
        .HREADYOUT1(HREADYOUT1), .HREADYOUT2(HREADYOUT2), .HREADYOUT3(HREADYOUT3),
        .HRESP1(HRESP1), .HRESP2(HRESP2), .HRESP3(HRESP3),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Reference model, transaction level: which subordinate owns the
    // current data phase (0 = none, 1..3, 4 = default), and how many
    // cycles of the default ERROR response remain (2 = first, 1 = second).
    int  m_owner    = 0;
    int  m_err_left = 0;
    bit  m_known    = 0;
    logic [DW-1:0] e_data;
    logic          e_ready;
    logic [RW-1:0] e_resp;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_expect();
        e_data  = '0;
        e_ready = 1'b1;
        e_resp  = '0;
        case (m_owner)
            1: begin e_data = HRDATA1; e_ready = HREADYOUT1; e_resp = HRESP1; end
            2: begin e_data = HRDATA2; e_ready = HREADYOUT2; e_resp = HRESP2; end
            3: begin e_data = HRDATA3; e_ready = HREADYOUT3; e_resp = HRESP3; end
            4: begin
                e_ready = (m_err_left != 2);
                e_resp  = RW'(m_err_left != 0);
            end
            default: ;
        endcase
    endfunction

    // One bus cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        int owner_new;
        @(negedge HCLK);
        model_expect();
        if (m_known) begin
            chk("hrdata", HRDATA, e_data);
            chk("hready", DW'(HREADY), DW'(e_ready));
            chk("hresp",  DW'(HRESP),  DW'(e_resp));
        end
        @(posedge HCLK);
        if (HRESET) begin
            m_owner = 0; m_err_left = 0; m_known = 1;
        end else begin
            if (m_err_left > 0) m_err_left--;
            if (e_ready) begin
                owner_new = HSEL1 ? 1 : HSEL2 ? 2 : HSEL3 ? 3 : HSELd ? 4 : 0;
                m_owner = owner_new;
                if (owner_new == 4 && HTRANS[1]) m_err_left = 2;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        HRESET = 0; HSEL1 = 0; HSEL2 = 0; HSEL3 = 0; HSELd = 0; HTRANS = 2'b00;
        HRDATA1 = '0; HRDATA2 = '0; HRDATA3 = '0;
        HREADYOUT1 = 1; HREADYOUT2 = 1; HREADYOUT3 = 1;
        HRESP1 = '0; HRESP2 = '0; HRESP3 = '0;
    endtask

    initial begin
        idle_inputs();
        HRESET = 1;
        step(); step();
        HRESET = 0;
        #1;
        chk("rst_hready", DW'(HREADY), 32'd1);
        chk("rst_hresp",  DW'(HRESP),  32'd0);
        chk("rst_hrdata", HRDATA,      32'd0);
        step(); step(); step();

        // Read from subordinate 1
        HSEL1 = 1; HTRANS = 2'b10; step();
        HSEL1 = 0; HTRANS = 2'b00; HRDATA1 = 32'hA5A5_0001; HREADYOUT1 = 1; #1;
        chk("s1_data",  HRDATA,      32'hA5A5_0001);
        chk("s1_ready", DW'(HREADY), 32'd1);
        step();

        // Subordinate 2 with three wait states while HSEL3 is requesting
        HSEL2 = 1; HTRANS = 2'b10; step();
        HSEL2 = 0; HSEL3 = 1; HREADYOUT2 = 0; HRDATA2 = 32'h2222_0000; HRDATA3 = 32'h3333_0000;
        for (int i = 0; i < 3; i++) begin
            HRDATA2 = 32'h2222_0000 + i; #1;
            chk("s2_wait_ready", DW'(HREADY), 32'd0);
            chk("s2_wait_data",  HRDATA,      32'h2222_0000 + i);
            step();
        end
        HREADYOUT2 = 1; HRDATA2 = 32'h2222_00FF; #1;
        chk("s2_done_data", HRDATA, 32'h2222_00FF);
        step();
        HSEL3 = 0; HTRANS = 2'b00; HRDATA3 = 32'h3333_0042; #1;
        chk("s3_after", HRDATA, 32'h3333_0042);
        step();

        // Default ERROR
        HSELd = 1; HTRANS = 2'b10; step();
        HSELd = 0; HTRANS = 2'b00; #1;
        chk("def_e1_ready", DW'(HREADY), 32'd0);
        chk("def_e1_resp",  DW'(HRESP),  32'd1);
        step(); #1;
        chk("def_e2_ready", DW'(HREADY), 32'd1);
        chk("def_e2_resp",  DW'(HRESP),  32'd1);
        step(); #1;
        chk("def_ok_resp", DW'(HRESP), 32'd0);

        // Default with HTRANS=IDLE: zero-wait OKAY
        HSELd = 1; HTRANS = 2'b00; step();
        HSELd = 0; #1;
        chk("def_idle_ready", DW'(HREADY), 32'd1);
        chk("def_idle_resp",  DW'(HRESP),  32'd0);
        step();

        // Back-to-back errors, second issued in ERR2
        HSELd = 1; HTRANS = 2'b10; step();
        HSELd = 0; HTRANS = 2'b00; step();
        HSELd = 1; HTRANS = 2'b11; #1;
        chk("b2b_e2_ready", DW'(HREADY), 32'd1);
        step();
        HSELd = 0; HTRANS = 2'b00; #1;
        chk("b2b_e1b_ready", DW'(HREADY), 32'd0);
        chk("b2b_e1b_resp",  DW'(HRESP),  32'd1);
        step(); step(); step();

        // Priority: all selects asserted resolve to subordinate 1
        HSEL1 = 1; HSEL2 = 1; HSEL3 = 1; HSELd = 1; HTRANS = 2'b10; step();
        HSEL1 = 0; HSEL2 = 0; HSEL3 = 0; HSELd = 0; HTRANS = 2'b00;
        HRDATA1 = 32'h1111_ABCD; HREADYOUT2 = 0; HREADYOUT3 = 0; #1;
        chk("prio_data",  HRDATA,      32'h1111_ABCD);
        chk("prio_ready", DW'(HREADY), 32'd1);
        chk("prio_resp",  DW'(HRESP),  32'd0);
        step();
        HREADYOUT2 = 1; HREADYOUT3 = 1;

        // Reset during ERR1
        HSELd = 1; HTRANS = 2'b10; step();
        HSELd = 0; HTRANS = 2'b00; HRESET = 1; step();
        HRESET = 0; #1;
        chk("rst_err_ready", DW'(HREADY), 32'd1);
        chk("rst_err_resp",  DW'(HRESP),  32'd0);
        step();

        // Reset during an S3 wait state
        HSEL3 = 1; HTRANS = 2'b10; step();
        HSEL3 = 0; HTRANS = 2'b00; HREADYOUT3 = 0; HRDATA3 = 32'hDEAD_BEEF; HRESET = 1; step();
        HRESET = 0; #1;
        chk("rst_s3_ready", DW'(HREADY), 32'd1);
        chk("rst_s3_data",  HRDATA,      32'd0);
        step();
        HREADYOUT3 = 1;

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            HSEL1 = ($urandom_range(0, 3) == 0);
            HSEL2 = ($urandom_range(0, 3) == 0);
            HSEL3 = ($urandom_range(0, 3) == 0);
            HSELd = ($urandom_range(0, 2) == 0);
            HTRANS = 2'($urandom_range(0, 3));
            HRDATA1 = $urandom; HRDATA2 = $urandom; HRDATA3 = $urandom;
            HREADYOUT1 = ($urandom_range(0, 9) < 7);
            HREADYOUT2 = ($urandom_range(0, 9) < 7);
            HREADYOUT3 = ($urandom_range(0, 9) < 7);
            HRESP1 = RW'($urandom_range(0, 1));
            HRESP2 = RW'($urandom_range(0, 1));
            HRESP3 = RW'($urandom_range(0, 1));
            HRESET = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
